// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: request/result bundle between the control unit (master) and the multiply/divide unit (slave).
interface mult_div_unit_if;
  logic        start;
  logic        op;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;
  modport master (output start, op, a_in, b_in, input hi, lo, busy, done, div_zero);
  modport slave (input start, op, a_in, b_in, output hi, lo, busy, done, div_zero);
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: 32-bit signed iterative multiply (shift-add) / divide (restoring) into HI/LO.
// Optional MULT_DIV_DIVZERO_EN: divide by zero short-circuits, keeps HI/LO and raises div_zero.
module mult_div_unit (
  input  logic           clock,
  input  logic           reset,
  mult_div_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_n;
  logic [5:0] count;
  logic op_r, neg_q, neg_r, accept, dz, skip, busy, done, ge;
  logic [31:0] mb, rem, hi_r, lo_r, abs_a, abs_b, shl, sub, quo_fix, rem_fix;
  logic [32:0] mul_sum;
  logic [63:0] acc, prod_fix;

  assign abs_a = bus.a_in[31] ? -bus.a_in : bus.a_in;
  assign abs_b = bus.b_in[31] ? -bus.b_in : bus.b_in;
  assign accept = bus.start && (state == IDLE || state == DONE);

`ifdef MULT_DIV_DIVZERO_EN
  logic div_zero;
  assign dz = bus.op && bus.b_in == 32'd0;
  assign skip = div_zero;
  always_ff @(posedge clock or posedge reset)
    if (reset) div_zero <= 1'b0;
    else if (accept) div_zero <= dz;
  assign bus.div_zero = div_zero;
`else
  assign dz = 1'b0;
  assign skip = 1'b0;
  assign bus.div_zero = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;

  // a short-circuited divide by zero spends its single busy cycle in FIX with the write suppressed
  always_comb
    state_n = state == CALC ? (count == 6'd31 ? FIX : CALC) :
              state == FIX  ? DONE :
              accept ? (dz ? FIX : CALC) : IDLE;

  always_comb begin
    busy = state == CALC || state == FIX;
    done = state == DONE;
  end

  // multiplier sits in acc[31:0] and is shifted out as the product shifts in from the top
  assign mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mb} : 33'd0);
  // divisor magnitude is at most 2^31, so a 32-bit remainder plus the 33-bit compare suffices
  assign shl = {rem[30:0], acc[31]};
  assign ge = {rem, acc[31]} >= {1'b0, mb};
  assign sub = shl - mb;
  assign prod_fix = neg_q ? -acc : acc;
  assign quo_fix = neg_q ? -acc[31:0] : acc[31:0];
  assign rem_fix = neg_r ? -rem : rem;

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      count <= '0;
      op_r <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      mb <= '0;
      acc <= '0;
      rem <= '0;
      hi_r <= '0;
      lo_r <= '0;
    end else if (accept) begin
      count <= '0;
      op_r <= bus.op;
      neg_q <= bus.a_in[31] ^ bus.b_in[31];
      neg_r <= bus.a_in[31];
      mb <= bus.op ? abs_b : abs_a;
      acc <= {32'd0, bus.op ? abs_a : abs_b};
      rem <= '0;
    end else if (state == CALC) begin
      count <= count + 6'd1;
      if (op_r) begin
        rem <= ge ? sub : shl;
        acc[31:0] <= {acc[30:0], ge};
      end else
        acc <= {mul_sum, acc[31:1]};
    end else if (state == FIX && !skip) begin
      hi_r <= op_r ? rem_fix : prod_fix[63:32];
      lo_r <= op_r ? quo_fix : prod_fix[31:0];
    end

  assign bus.hi = hi_r;
  assign bus.lo = lo_r;
  assign bus.busy = busy;
  assign bus.done = done;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: vector table, hand-written corner sequences and random ops against an arithmetic reference.
module tb_mult_div_unit;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [63:0] last = '0;

  mult_div_unit_if bus();
  mult_div_unit dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  typedef struct {
    logic        op;
    logic [31:0] a, b, hi, lo;
    logic        dz;
    int          k;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  function automatic void model(input logic o, input logic [31:0] a, input logic [31:0] b,
                                input logic [63:0] prev, output logic [63:0] res,
                                output logic dz, output int k);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    dz = 1'b0;
    k = 33;
    if (!o) res = 64'(sa * sb);
    else if (b == 32'd0) begin
`ifdef MULT_DIV_DIVZERO_EN
      res = prev;
      dz = 1'b1;
      k = 1;
`else
      res = {a, a[31] ? 32'd1 : 32'hFFFFFFFF};
`endif
    end else res = {32'(sa % sb), 32'(sa / sb)};
  endfunction

  // caller sits at a falling edge; the request is taken at the next rising edge
  task automatic issue(input logic o, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op = o;
    bus.a_in = a;
    bus.b_in = b;
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int intr, output int k, output int busy_n);
    k = 0;
    busy_n = 0;
    while (!bus.done && k < 100) begin
      busy_n += int'(bus.busy);
      bus.start = (k == intr);
      if (k == intr) begin
        bus.op = ~bus.op;
        bus.a_in = 32'd1;
        bus.b_in = 32'd1;
      end
      @(negedge clock);
      k++;
    end
    bus.start = 1'b0;
    if (!bus.done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout got none want pulse");
    end
  endtask

  task automatic run_check(input string name, input logic o, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp, input logic edz, input int ek, input int intr);
    int k, bn;
    issue(o, a, b);
    wait_done(intr, k, bn);
    chk({name, " hilo"}, {bus.hi, bus.lo}, exp);
    chk({name, " div_zero"}, 64'(bus.div_zero), 64'(edz));
    chk({name, " latency"}, 64'(k), 64'(ek));
    chk({name, " busy_cycles"}, 64'(bn), 64'(ek));
    chk({name, " busy_in_done"}, 64'(bus.busy), 64'd0);
    last = {bus.hi, bus.lo};
  endtask

  initial begin
    int k, bn;
    logic [63:0] res;
    logic edz;
    int ek;
    logic o;
    logic [31:0] a, b;
    vt[0]  = '{1'b0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33};
`ifdef MULT_DIV_DIVZERO_EN
    vt[1]  = '{1'b1, 32'd5, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b1, 1};
`else
    vt[1]  = '{1'b1, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b0, 33};
`endif
    vt[2]  = '{1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
    vt[3]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, 33};
    vt[4]  = '{1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'd1, 1'b0, 33};
    vt[5]  = '{1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0, 1'b0, 33};
    vt[6]  = '{1'b1, 32'd100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFF2, 1'b0, 33};
    vt[7]  = '{1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0, 33};
    vt[8]  = '{1'b0, 32'd0, 32'h12345678, 32'd0, 32'd0, 1'b0, 33};
`ifdef MULT_DIV_DIVZERO_EN
    vt[9]  = '{1'b1, 32'hFFFFFFF9, 32'd0, 32'd0, 32'd0, 1'b1, 1};
`else
    vt[9]  = '{1'b1, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'd1, 1'b0, 33};
`endif
    vt[10] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd1, 1'b0, 33};
    vt[11] = '{1'b1, 32'd3, 32'd10, 32'd3, 32'd0, 1'b0, 33};
    vt[12] = '{1'b0, 32'h00010000, 32'h00010000, 32'd1, 32'd0, 1'b0, 33};

    bus.start = 1'b0;
    bus.op = 1'b0;
    bus.a_in = '0;
    bus.b_in = '0;
    repeat (3) @(negedge clock);
    chk("reset hilo", {bus.hi, bus.lo}, 64'd0);
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset done", 64'(bus.done), 64'd0);
    chk("reset div_zero", 64'(bus.div_zero), 64'd0);
    reset = 1'b0;

    foreach (vt[i])
      run_check($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, {vt[i].hi, vt[i].lo}, vt[i].dz, vt[i].k, -1);

    run_check("ignored_start", 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, {32'h3FFFFFFF, 32'd1}, 1'b0, 33, 10);

    issue(1'b1, 32'd9, 32'd4);
    wait_done(-1, k, bn);
    chk("b2b first hilo", {bus.hi, bus.lo}, {32'd1, 32'd2});
    issue(1'b0, 32'd2, 32'd3);
    wait_done(-1, k, bn);
    chk("b2b second hilo", {bus.hi, bus.lo}, {32'd0, 32'd6});
    chk("b2b second latency", 64'(k), 64'd33);

    issue(1'b0, 32'd1234, 32'd5678);
    repeat (15) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("abort busy", 64'(bus.busy), 64'd0);
    chk("abort hilo", {bus.hi, bus.lo}, 64'd0);
    repeat (3) @(negedge clock);
    chk("abort done", 64'(bus.done), 64'd0);
    reset = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (bus.done) chk("abort stray_done", 64'(bus.done), 64'd0);
    end
    chk("abort hilo_after", {bus.hi, bus.lo}, 64'd0);
    last = '0;
    run_check("after_abort", 1'b0, 32'd4, 32'd4, {32'd0, 32'd16}, 1'b0, 33, -1);

    for (int n = 0; n < 30; n++) begin
      o = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 3) == 0) ? 32'($signed($urandom_range(0, 40)) - 20) : $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFFFFFF;
        2: b = 32'($signed($urandom_range(0, 40)) - 20);
        default: b = $urandom;
      endcase
      model(o, a, b, last, res, edz, ek);
      run_check($sformatf("rand%0d", n), o, a, b, res, edz, ek, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
